sc_lane_shifter: RTL
====================

SC_LANE_SHIFTER -- requirements
Module: sc_lane_shifter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATAWIDTH_BUS, 8, lane pattern width.
- DIR, 0, rotation direction: 0 rotates left (bit 7 wraps into bit 0), 1 rotates right (bit 0 wraps into bit 7).
- TICK_BASE, 2500000, fast-speed period in clocks.
- CNTW, 24, prescaler counter width; SHALL hold 4*TICK_BASE-1.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- SC_STATEMACHINE_NVE_CLOCK_50, in, 1, clock.
- SC_STATEMACHINE_NVE_RESET, in, 1, asynchronous active-high reset.
- LANE_LOAD_SHIFT_IN, in, 1: 1 = load, 0 = shift. Driven by the level state machine's load/shift output.
- LANE_DATA_IN, in, DATAWIDTH_BUS: pattern to load. Driven by the level state machine's level-register output.
- LANE_VEL_SELECT_IN, in, 2: speed code. Driven by the level state machine's speed-select output.
- LANE_FROG_POS_IN, in, DATAWIDTH_BUS: one-hot frog column.
- LANE_FROG_HERE_IN, in, 1: frog occupies this lane.
- LANE_DATA_OUT, out, DATAWIDTH_BUS: registered lane pattern.
- LANE_TICK_OUT, out, 1: registered one-cycle pulse on each rotation.
- LANE_COLLISION_OUT, out, 1: registered sticky collision flag.

Function
REQ-003 Period P SHALL be set by LANE_VEL_SELECT_IN:
- 00: stopped.
- 01: P = 4*TICK_BASE.
- 10: P = 2*TICK_BASE.
- 11: P = TICK_BASE.

REQ-004 The block SHALL have two modes:
- LOAD (LANE_LOAD_SHIFT_IN=1).
- SHIFT (LANE_LOAD_SHIFT_IN=0).
Mode SHALL be re-evaluated every clock edge, with no latency.

REQ-005 In LOAD, each edge SHALL set:
- LANE_DATA_OUT <= LANE_DATA_IN.
- Counter <= 0.
- LANE_TICK_OUT <= 0.
- LANE_COLLISION_OUT <= 0.

REQ-006 In SHIFT with speed 00, the block SHALL hold LANE_DATA_OUT, hold the counter at 0, and drive LANE_TICK_OUT=0.

REQ-007 In SHIFT with speed ≠ 00, the counter SHALL increment each edge while below P-1.

REQ-008 When the counter is ≥ P-1 at an edge in SHIFT with speed ≠ 00, that edge SHALL:
- Reset the counter to 0.
- Rotate LANE_DATA_OUT once in direction DIR.
- Set LANE_TICK_OUT to 1 for exactly that cycle.

REQ-009 The first rotation after entering SHIFT from LOAD SHALL occur on the P-th edge; later rotations SHALL occur every P edges.

REQ-010 A speed change mid-count SHALL NOT reset the counter. If the counter already meets or exceeds the new P-1, the next edge SHALL rotate (per REQ-008).

REQ-011 Rotation SHALL be lossless: the popcount of LANE_DATA_OUT is preserved, and an all-zero pattern stays all-zero with ticks still generated.

REQ-012 Each edge in SHIFT, LANE_COLLISION_OUT SHALL be set to 1 if LANE_FROG_HERE_IN=1 and (LANE_DATA_OUT & LANE_FROG_POS_IN) ≠ 0, evaluated on pre-edge values. Latency is one clock.

REQ-013 LANE_COLLISION_OUT SHALL stay 1 until a LOAD cycle or reset. If a LOAD cycle and a collision condition occur on the same edge, LOAD SHALL win and the flag SHALL be cleared.

REQ-014 A collision SHALL NOT stop rotation.

Reset
REQ-015 On SC_STATEMACHINE_NVE_RESET=1, the block SHALL immediately, without waiting for a clock, set LANE_DATA_OUT=0, counter=0, LANE_TICK_OUT=0 and LANE_COLLISION_OUT=0.

REQ-016 Outputs SHALL hold those values while reset is asserted.

REQ-017 Reset asserted mid-count SHALL discard the partial count. After release, the first rotation SHALL need a full P edges.

Verification (TICK_BASE=2, so fast=2, medium=4, slow=8)
REQ-018 Load and fast rotate: load 8'b1000_0001 for one cycle, then SHIFT at speed 11 with DIR=0. Required: 8'b0000_0011 after 2 edges, then 8'b0000_0110 after 2 more; LANE_TICK_OUT high one cycle every 2.

REQ-019 Slow speed and stop: load 8'b0000_0001, SHIFT at speed 01. Required: first rotation to 8'b0000_0010 on edge 8. Then at speed 00 for 20 cycles, the pattern holds and LANE_TICK_OUT stays 0.

REQ-020 Speed change mid-count: at speed 01, after the counter reaches 5, switch to speed 11. Required: rotation and tick on the very next edge, then every 2 edges.

REQ-021 DIR=1 wrap: load 8'b0000_0001, SHIFT at speed 11. Required: 8'b1000_0000 after 2 edges.

REQ-022 Collision: LANE_DATA_OUT=8'b0001_0000, LANE_FROG_POS_IN=8'b0001_0000, LANE_FROG_HERE_IN=1 at speed 00. Required:
- LANE_COLLISION_OUT=1 on the next edge.
- Stays 1 after LANE_FROG_HERE_IN drops.
- Clears on a LOAD cycle.
- Load plus collision on the same edge gives 0.

REQ-023 Reset mid-operation: at speed 10 with the counter at 3, assert reset asynchronously. Required: all outputs 0 before the next edge. After release, load 8'b0000_0001 for one cycle, then SHIFT at speed 10; the first rotation occurs 4 edges later.

Source files
------------

// File: rtl/sc_lane_shifter.sv
// Lane pattern rotator for the road/river lanes: loads a pattern, rotates it at
// one of three speeds, and flags a sticky collision with the frog.
module sc_lane_shifter #(
  parameter int unsigned DATAWIDTH_BUS = 8,
  parameter int unsigned DIR           = 0,
  parameter int unsigned TICK_BASE     = 2500000,
  parameter int unsigned CNTW          = 24
) (
  input  logic                     SC_STATEMACHINE_NVE_CLOCK_50,
  input  logic                     SC_STATEMACHINE_NVE_RESET,
  input  logic                     LANE_LOAD_SHIFT_IN,
  input  logic [DATAWIDTH_BUS-1:0] LANE_DATA_IN,
  input  logic [1:0]               LANE_VEL_SELECT_IN,
  input  logic [DATAWIDTH_BUS-1:0] LANE_FROG_POS_IN,
  input  logic                     LANE_FROG_HERE_IN,
  output logic [DATAWIDTH_BUS-1:0] LANE_DATA_OUT,
  output logic                     LANE_TICK_OUT,
  output logic                     LANE_COLLISION_OUT
);

  typedef enum logic [1:0] {
    SPD_STOP = 2'b00,
    SPD_SLOW = 2'b01,
    SPD_MED  = 2'b10,
    SPD_FAST = 2'b11
  } speed_t;

  localparam logic [CNTW-1:0] P_SLOW_M1 = CNTW'(4 * TICK_BASE - 1);
  localparam logic [CNTW-1:0] P_MED_M1  = CNTW'(2 * TICK_BASE - 1);
  localparam logic [CNTW-1:0] P_FAST_M1 = CNTW'(TICK_BASE - 1);

  logic [DATAWIDTH_BUS-1:0] r_data;
  logic [CNTW-1:0]          r_cnt;
  logic                     r_tick;
  logic                     r_coll;

  speed_t                   w_speed;
  logic [CNTW-1:0]          w_period_m1;
  logic [DATAWIDTH_BUS-1:0] w_rotated;
  logic                     w_hit;

  assign w_speed = speed_t'(LANE_VEL_SELECT_IN);

  always_comb begin
    w_period_m1 = '0;
    unique case (w_speed)
      SPD_SLOW: w_period_m1 = P_SLOW_M1;
      SPD_MED:  w_period_m1 = P_MED_M1;
      SPD_FAST: w_period_m1 = P_FAST_M1;
      default:  w_period_m1 = '0;
    endcase
  end

  // DIR=0 moves bits toward the MSB with the MSB wrapping to bit 0; DIR=1 the reverse.
  generate
    if (DIR == 0) begin : g_rot_left
      assign w_rotated = {r_data[DATAWIDTH_BUS-2:0], r_data[DATAWIDTH_BUS-1]};
    end else begin : g_rot_right
      assign w_rotated = {r_data[0], r_data[DATAWIDTH_BUS-1:1]};
    end
  endgenerate

  assign w_hit = LANE_FROG_HERE_IN && (|(r_data & LANE_FROG_POS_IN));

  always_ff @(posedge SC_STATEMACHINE_NVE_CLOCK_50 or posedge SC_STATEMACHINE_NVE_RESET) begin
    if (SC_STATEMACHINE_NVE_RESET) begin
      r_data <= '0;
      r_cnt  <= '0;
      r_tick <= 1'b0;
      r_coll <= 1'b0;
    end else if (LANE_LOAD_SHIFT_IN) begin
      r_data <= LANE_DATA_IN;
      r_cnt  <= '0;
      r_tick <= 1'b0;
      r_coll <= 1'b0;
    end else begin
      r_coll <= r_coll | w_hit;
      if (w_speed == SPD_STOP) begin
        r_cnt  <= '0;
        r_tick <= 1'b0;
      end else if (r_cnt >= w_period_m1) begin
        // >= so a switch to a faster speed mid-count rotates on the next edge.
        r_cnt  <= '0;
        r_data <= w_rotated;
        r_tick <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
        r_tick <= 1'b0;
      end
    end
  end

  assign LANE_DATA_OUT      = r_data;
  assign LANE_TICK_OUT      = r_tick;
  assign LANE_COLLISION_OUT = r_coll;

endmodule
